// File: rtl/nasti_wr_sched.sv
// nasti_wr_sched: write-path scheduler for an N-port NASTI write mux.
//
// Picks one requesting port round-robin for the AW channel, keeps that port
// selected for its whole W burst (length from aw_len), and remembers every
// accepted write as an {id, port} entry so that B responses can be steered
// back to the port that issued them. The data muxes themselves live outside;
// this block only produces selects, channel enables and bookkeeping.
//
// Handshake semantics: a transfer happens on a channel in a cycle where both
// its valid and its ready are 1 at the rising clock edge. A source, once it
// raises valid, keeps valid and payload stable until that transfer happens.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_aw_valid   per-port AW valid
//   req_aw_id      per-port AW id, port p at [p*ID_WIDTH +: ID_WIDTH]
//   req_aw_len     per-port AW len, port p at [p*8 +: 8]
//   m_aw_ready     downstream AW ready
//   w_valid_sel    w_valid of the selected port
//   w_last_sel     w_last of the selected port
//   m_w_ready      downstream W ready
//   m_b_valid      downstream B valid
//   m_b_id         downstream B id
//   b_ready_sel    b_ready of the port addressed by b_sel
//   aw_sel         port driving downstream AW and W
//   aw_en          gate for downstream aw_valid
//   w_en           gate for downstream w_valid
//   b_sel          port receiving the current B
//   b_hit          m_b_id matched an outstanding entry
//   m_b_ready      downstream B ready
//   outstanding    number of valid table entries
//   proto_err      sticky: w_last mismatch or orphan B
//   state_dbg      current FSM state (0 IDLE, 1 ADDR, 2 DATA)
module nasti_wr_sched #(
  parameter int N_PORT   = 4,
  parameter int W_MAX    = 2,
  parameter int ID_WIDTH = 1,
  localparam int SEL_W   = $clog2(N_PORT),
  localparam int CNT_W   = $clog2(W_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORT-1:0]          req_aw_valid,
  input  logic [N_PORT*ID_WIDTH-1:0] req_aw_id,
  input  logic [N_PORT*8-1:0]        req_aw_len,
  input  logic                       m_aw_ready,
  input  logic                       w_valid_sel,
  input  logic                       w_last_sel,
  input  logic                       m_w_ready,
  input  logic                       m_b_valid,
  input  logic [ID_WIDTH-1:0]        m_b_id,
  input  logic                       b_ready_sel,
  output logic [SEL_W-1:0]           aw_sel,
  output logic                       aw_en,
  output logic                       w_en,
  output logic [SEL_W-1:0]           b_sel,
  output logic                       b_hit,
  output logic                       m_b_ready,
  output logic [CNT_W-1:0]           outstanding,
  output logic                       proto_err,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   aw_sel_n, rr_ptr, rr_ptr_n, pick_sel;
  logic [7:0]         beat_cnt, beat_cnt_n, sel_len;
  logic [ID_WIDTH-1:0] sel_id;
  logic [N_PORT-1:0]  elig;
  logic               pick_found, tbl_full, tbl_wr, w_err;
  logic               b_found, b_retire, b_orphan;
  logic [W_MAX-1:0]   free_oh, hit_oh, free_seen;

  logic [W_MAX-1:0]    tbl_valid;
  logic [ID_WIDTH-1:0] tbl_id   [W_MAX];
  logic [SEL_W-1:0]    tbl_port [W_MAX];

  assign state_dbg = state;

  // Occupancy is derived from the valid bits so it can never disagree with
  // the table contents.
  always_comb begin
    outstanding = '0;
    for (int e = 0; e < W_MAX; e++) outstanding = outstanding + CNT_W'(tbl_valid[e]);
  end
  assign tbl_full = (outstanding == CNT_W'(W_MAX));

  // A port is blocked while another port owns an outstanding write with the
  // same id, otherwise B responses for that id could not be told apart.
  always_comb begin
    int idx;
    elig = '0;
    for (int p = 0; p < N_PORT; p++) begin
      elig[p] = req_aw_valid[p];
      for (int e = 0; e < W_MAX; e++)
        if (tbl_valid[e] && tbl_id[e] == req_aw_id[p*ID_WIDTH +: ID_WIDTH] &&
            tbl_port[e] != SEL_W'(p))
          elig[p] = 1'b0;
    end
    pick_found = 1'b0;
    pick_sel   = '0;
    idx        = 0;
    for (int i = 0; i < N_PORT; i++) begin
      idx = (int'(rr_ptr) + i) % N_PORT;
      if (!pick_found && elig[idx]) begin
        pick_found = 1'b1;
        pick_sel   = SEL_W'(idx);
      end
    end
  end

  // Payload of the currently granted port.
  always_comb begin
    sel_len = '0;
    sel_id  = '0;
    for (int p = 0; p < N_PORT; p++)
      if (aw_sel == SEL_W'(p)) begin
        sel_len = req_aw_len[p*8 +: 8];
        sel_id  = req_aw_id[p*ID_WIDTH +: ID_WIDTH];
      end
  end

  // Lowest invalid entry, taken from the registered valid bits so a slot
  // freed by a B in the same cycle is only reused from the next cycle.
  always_comb begin
    free_oh   = '0;
    free_seen = '0;
    for (int e = 0; e < W_MAX; e++) begin
      if (e > 0) free_seen[e] = free_seen[e-1] | free_oh[e-1];
      free_oh[e] = !tbl_valid[e] && !free_seen[e];
    end
  end

  // B routing: lowest matching entry wins. An unmatched B is accepted and
  // dropped so the downstream channel cannot deadlock.
  always_comb begin
    hit_oh  = '0;
    b_found = 1'b0;
    b_sel   = '0;
    for (int e = 0; e < W_MAX; e++)
      if (!b_found && tbl_valid[e] && tbl_id[e] == m_b_id) begin
        b_found   = 1'b1;
        hit_oh[e] = 1'b1;
        b_sel     = tbl_port[e];
      end
    b_hit     = m_b_valid && b_found;
    m_b_ready = m_b_valid && (b_found ? b_ready_sel : 1'b1);
    b_retire  = b_hit && m_b_ready;
    b_orphan  = m_b_valid && !b_found;
  end

  // FSM next state and channel enables.
  always_comb begin
    state_n    = state;
    aw_sel_n   = aw_sel;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    aw_en      = 1'b0;
    w_en       = 1'b0;
    tbl_wr     = 1'b0;
    w_err      = 1'b0;
    case (state)
      IDLE: begin
        if (!tbl_full && pick_found) begin
          aw_sel_n = pick_sel;
          rr_ptr_n = (pick_sel == SEL_W'(N_PORT - 1)) ? '0 : pick_sel + SEL_W'(1);
          state_n  = ADDR;
        end
      end
      ADDR: begin
        // The grant is held even if the port withdraws its request.
        aw_en = 1'b1;
        if (m_aw_ready) begin
          tbl_wr     = 1'b1;
          beat_cnt_n = sel_len;
          state_n    = DATA;
        end
      end
      DATA: begin
        w_en = 1'b1;
        if (w_valid_sel && m_w_ready) begin
          if (beat_cnt == 8'd0) begin
            state_n = IDLE;
            w_err   = !w_last_sel;
          end else begin
            beat_cnt_n = beat_cnt - 8'd1;
            w_err      = w_last_sel;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      aw_sel    <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
      tbl_valid <= '0;
      for (int e = 0; e < W_MAX; e++) begin
        tbl_id[e]   <= '0;
        tbl_port[e] <= '0;
      end
    end else begin
      state     <= state_n;
      aw_sel    <= aw_sel_n;
      rr_ptr    <= rr_ptr_n;
      beat_cnt  <= beat_cnt_n;
      proto_err <= proto_err | w_err | b_orphan;
      for (int e = 0; e < W_MAX; e++) begin
        if (tbl_wr && free_oh[e]) begin
          tbl_valid[e] <= 1'b1;
          tbl_id[e]    <= sel_id;
          tbl_port[e]  <= aw_sel;
        end else if (b_retire && hit_oh[e]) begin
          tbl_valid[e] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nasti_wr_sched.sv
module tb_nasti_wr_sched;
  localparam int N_PORT   = 4;
  localparam int W_MAX    = 2;
  localparam int ID_WIDTH = 1;

  logic        clk;
  logic        rst;
  logic [3:0]  req_aw_valid;
  logic [3:0]  req_aw_id;
  logic [31:0] req_aw_len;
  logic        m_aw_ready, w_valid_sel, w_last_sel, m_w_ready;
  logic        m_b_valid;
  logic [0:0]  m_b_id;
  logic        b_ready_sel;
  logic [1:0]  aw_sel, b_sel;
  logic        aw_en, w_en, b_hit, m_b_ready, proto_err;
  logic [1:0]  outstanding;
  logic [1:0]  state_dbg;

  int tests;
  int fails;

  nasti_wr_sched #(.N_PORT(N_PORT), .W_MAX(W_MAX), .ID_WIDTH(ID_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_aw_valid(req_aw_valid), .req_aw_id(req_aw_id), .req_aw_len(req_aw_len),
    .m_aw_ready(m_aw_ready), .w_valid_sel(w_valid_sel), .w_last_sel(w_last_sel),
    .m_w_ready(m_w_ready), .m_b_valid(m_b_valid), .m_b_id(m_b_id),
    .b_ready_sel(b_ready_sel), .aw_sel(aw_sel), .aw_en(aw_en), .w_en(w_en),
    .b_sel(b_sel), .b_hit(b_hit), .m_b_ready(m_b_ready),
    .outstanding(outstanding), .proto_err(proto_err), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic id, input logic [7:0] len);
    req_aw_valid[p]      = 1'b1;
    req_aw_id[p]         = id;
    req_aw_len[p*8 +: 8] = len;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_aw_valid = '0;
    req_aw_id    = '0;
    req_aw_len   = '0;
    m_aw_ready   = 1'b1;
    w_valid_sel  = 1'b1;
    w_last_sel   = 1'b1;
    m_w_ready    = 1'b1;
    m_b_valid    = 1'b0;
    m_b_id       = '0;
    b_ready_sel  = 1'b1;

    // Reset values
    repeat (2) tick();
    chk("rst_state", state_dbg, 0);
    chk("rst_aw_sel", aw_sel, 0);
    chk("rst_aw_en", aw_en, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_b_hit", b_hit, 0);
    chk("rst_m_b_ready", m_b_ready, 0);
    rst = 1'b0;

    // Ports 1 and 3 request single-beat writes: port1 first, then port3
    set_req(1, 1'b0, 8'd0);
    set_req(3, 1'b1, 8'd0);
    #1;
    chk("t1_aw_en_pre", aw_en, 0);
    tick();
    chk("t1_aw_en_p1", aw_en, 1);
    chk("t1_aw_sel_p1", aw_sel, 1);
    tick();
    req_aw_valid[1] = 1'b0;
    chk("t1_w_en_p1", w_en, 1);
    chk("t1_aw_en_off", aw_en, 0);
    chk("t1_out1", outstanding, 1);
    tick();
    chk("t1_idle_p1", state_dbg, 0);
    tick();
    chk("t1_aw_en_p3", aw_en, 1);
    chk("t1_aw_sel_p3", aw_sel, 3);
    tick();
    req_aw_valid[3] = 1'b0;
    chk("t1_out2", outstanding, 2);
    tick();
    chk("t1_idle_p3", state_dbg, 0);
    chk("t1_no_err", proto_err, 0);

    // Table full: port2 waits until a B retires an entry
    set_req(2, 1'b0, 8'd0);
    repeat (3) tick();
    chk("t3_full_no_grant", aw_en, 0);
    chk("t3_full_idle", state_dbg, 0);
    m_b_valid = 1'b1;
    m_b_id    = 1'b0;
    #1;
    chk("t3_b_hit", b_hit, 1);
    chk("t3_b_sel", b_sel, 1);
    chk("t3_m_b_ready", m_b_ready, 1);
    tick();
    m_b_valid = 1'b0;
    chk("t3_out_after_retire", outstanding, 1);
    chk("t3_aw_en_retire_cycle", aw_en, 0);
    tick();
    chk("t3_aw_en_regrant", aw_en, 1);
    chk("t3_aw_sel_p2", aw_sel, 2);
    tick();
    req_aw_valid[2] = 1'b0;
    chk("t3_out_refill", outstanding, 2);
    tick();
    chk("t3_idle", state_dbg, 0);

    // B held off by the port, then both entries retired
    m_b_valid   = 1'b1;
    m_b_id      = 1'b1;
    b_ready_sel = 1'b0;
    #1;
    chk("tb_hold_m_b_ready", m_b_ready, 0);
    chk("tb_hold_b_hit", b_hit, 1);
    chk("tb_hold_b_sel", b_sel, 3);
    tick();
    chk("tb_hold_out", outstanding, 2);
    b_ready_sel = 1'b1;
    #1;
    chk("tb_release_m_b_ready", m_b_ready, 1);
    tick();
    m_b_id = 1'b0;
    #1;
    chk("tb_b_sel_p2", b_sel, 2);
    tick();
    m_b_valid = 1'b0;
    chk("tb_out_empty", outstanding, 0);

    // Port0 four-beat burst with m_w_ready toggling
    set_req(0, 1'b0, 8'd3);
    w_last_sel = 1'b0;
    tick();
    chk("t2_aw_en", aw_en, 1);
    chk("t2_aw_sel", aw_sel, 0);
    tick();
    req_aw_valid[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      m_w_ready  = (k % 2 == 0);
      w_last_sel = (k == 6);
      #1;
      chk($sformatf("t2_w_en_k%0d", k), w_en, 1);
      tick();
    end
    chk("t2_w_en_done", w_en, 0);
    chk("t2_idle", state_dbg, 0);
    chk("t2_no_err", proto_err, 0);
    chk("t2_out", outstanding, 1);
    m_w_ready  = 1'b1;
    w_last_sel = 1'b1;
    m_b_valid  = 1'b1;
    m_b_id     = 1'b0;
    #1;
    chk("t2_b_sel", b_sel, 0);
    tick();
    m_b_valid = 1'b0;
    chk("t2_out_empty", outstanding, 0);

    // Id conflict: port0 owns id1, port1 (id1) blocked, port2 (id0) granted
    set_req(0, 1'b1, 8'd0);
    tick();
    chk("t4_aw_sel_p0", aw_sel, 0);
    tick();
    req_aw_valid[0] = 1'b0;
    tick();
    chk("t4_out1", outstanding, 1);
    set_req(1, 1'b1, 8'd0);
    set_req(2, 1'b0, 8'd0);
    tick();
    chk("t4_aw_en", aw_en, 1);
    chk("t4_conflict_skip", aw_sel, 2);
    tick();
    req_aw_valid[2] = 1'b0;
    tick();
    chk("t4_out2", outstanding, 2);
    chk("t4_p1_blocked", aw_en, 0);
    m_b_valid = 1'b1;
    m_b_id    = 1'b1;
    #1;
    chk("t4_b_sel", b_sel, 0);
    chk("t4_b_hit", b_hit, 1);
    tick();
    m_b_valid = 1'b0;
    chk("t4_aw_en_retire_cycle", aw_en, 0);
    tick();
    chk("t4_aw_en_p1", aw_en, 1);
    chk("t4_aw_sel_p1", aw_sel, 1);
    tick();
    req_aw_valid[1] = 1'b0;
    tick();
    chk("t4_idle", state_dbg, 0);
    chk("t4_out_full", outstanding, 2);
    m_b_valid = 1'b1;
    m_b_id    = 1'b0;
    #1;
    chk("t4_b_sel_p2", b_sel, 2);
    tick();
    m_b_id = 1'b1;
    #1;
    chk("t4_b_sel_p1", b_sel, 1);
    tick();
    m_b_valid = 1'b0;
    chk("t4_out_empty", outstanding, 0);

    // Orphan B: dropped and flagged, flag sticky
    m_b_valid   = 1'b1;
    m_b_id      = 1'b0;
    b_ready_sel = 1'b0;
    #1;
    chk("t5_b_hit", b_hit, 0);
    chk("t5_m_b_ready", m_b_ready, 1);
    chk("t5_err_before", proto_err, 0);
    tick();
    m_b_valid   = 1'b0;
    b_ready_sel = 1'b1;
    chk("t5_err_set", proto_err, 1);
    repeat (3) tick();
    chk("t5_err_sticky", proto_err, 1);

    // Reset mid-burst with beat_cnt at 2
    set_req(2, 1'b0, 8'd5);
    tick();
    chk("t6_aw_sel", aw_sel, 2);
    tick();
    req_aw_valid[2] = 1'b0;
    w_last_sel = 1'b0;
    m_w_ready  = 1'b1;
    repeat (3) tick();
    chk("t6_in_burst", w_en, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_aw_en", aw_en, 0);
    chk("t6_rst_w_en", w_en, 0);
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_err", proto_err, 0);
    chk("t6_rst_state", state_dbg, 0);
    #1;
    rst = 1'b0;
    // Next write granted normally; missing w_last on the final beat flags error
    set_req(3, 1'b1, 8'd0);
    tick();
    chk("t6_regrant_aw_en", aw_en, 1);
    chk("t6_regrant_sel", aw_sel, 3);
    tick();
    req_aw_valid[3] = 1'b0;
    chk("t6_w_en", w_en, 1);
    tick();
    chk("t6_idle", state_dbg, 0);
    chk("t6_last_missing_err", proto_err, 1);
    chk("t6_out", outstanding, 1);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
